// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings and
// the default register-address width.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RA_W = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load in EX is about to produce. Register 0 is hardwired and never hazards.
module pipeline_hazard_ctrl_hazard_cmp #(
  parameter int unsigned RA_W = pipeline_hazard_ctrl_pkg::RA_W
) (
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_we,
  output logic            load_use_c
);

  logic rd_valid_c;
  logic rs1_hit_c;
  logic rs2_hit_c;

  always_comb begin
    rd_valid_c = ex_is_load & ex_we & (ex_rd != '0);
    rs1_hit_c  = id_use_rs1 & (id_rs1 == ex_rd);
    rs2_hit_c  = id_use_rs2 & (id_rs2 == ex_rd);
    load_use_c = rd_valid_c & (rs1_hit_c | rs2_hit_c);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// Enables and flushes are combinational from state and inputs (0-cycle latency).
module pipeline_hazard_ctrl #(
  parameter int unsigned RA_W         = pipeline_hazard_ctrl_pkg::RA_W,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_we,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             we_if_id,
  output logic             we_id_ex,
  output logic             we_ex_mem,
  output logic             we_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use_c;
  logic mem_wait_c;
  logic pc_we_c, we_if_id_c, we_id_ex_c, we_ex_mem_c, we_mem_wb_c;
  logic flush_if_id_c, flush_id_ex_c;

  pipeline_hazard_ctrl_hazard_cmp #(
    .RA_W (RA_W)
  ) u_hazard_cmp (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .ex_we      (ex_we),
    .load_use_c (load_use_c)
  );

  // Once parked in MEM_WAIT only the ack releases the pipeline.
  always_comb begin
    if (state_q == ST_MEM_WAIT) begin
      mem_wait_c = ~mem_ack;
    end else begin
      mem_wait_c = mem_req & ~mem_ack;
    end
  end

  // Next state and enables; priority is memory wait > branch > FLUSH tail > load-use.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pc_we_c       = 1'b1;
    we_if_id_c    = 1'b1;
    we_id_ex_c    = 1'b1;
    we_ex_mem_c   = 1'b1;
    we_mem_wb_c   = 1'b1;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;

    if (mem_wait_c) begin
      pc_we_c     = 1'b0;
      we_if_id_c  = 1'b0;
      we_id_ex_c  = 1'b0;
      we_ex_mem_c = 1'b0;
      we_mem_wb_c = 1'b0;
      // A wait inside FLUSH keeps the state so the remaining flush cycles resume.
      if (state_q != ST_FLUSH) begin
        state_d = ST_MEM_WAIT;
      end
    end else if (ex_branch_taken) begin
      flush_if_id_c = 1'b1;
      flush_id_ex_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FC_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_FLUSH) begin
      flush_if_id_c = 1'b1;
      fcnt_d        = fcnt_q - FC_W'(1);
      if (fcnt_q <= FC_W'(1)) begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (load_use_c) begin
        pc_we_c       = 1'b0;
        we_if_id_c    = 1'b0;
        flush_id_ex_c = 1'b1;
      end
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (!pc_we_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces every enable and flush low without waiting for a clock.
  always_comb begin
    pc_we       = pc_we_c & ~rst;
    we_if_id    = we_if_id_c & ~rst;
    we_id_ex    = we_id_ex_c & ~rst;
    we_ex_mem   = we_ex_mem_c & ~rst;
    we_mem_wb   = we_mem_wb_c & ~rst;
    flush_if_id = flush_if_id_c & ~rst;
    flush_id_ex = flush_id_ex_c & ~rst;
    state       = 2'(state_q);
    stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; a second instance with
// a 4-bit counter checks stall_cnt saturation.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RA_W = 4;

  logic            clk;
  logic            rst;
  logic [RA_W-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_is_load, ex_we;
  logic            ex_branch_taken, mem_req, mem_ack, cnt_clr;

  logic        pc_we, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, flush_if_id, flush_id_ex;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  logic        s_pc_we, s_we_if_id, s_we_id_ex, s_we_ex_mem, s_we_mem_wb;
  logic        s_flush_if_id, s_flush_id_ex;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cnt;

  logic [6:0]  en;

  int total;
  int bad;

  // {pc_we, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, flush_if_id, flush_id_ex}
  localparam logic [6:0] EN_RUN = 7'b1111100;
  localparam logic [6:0] EN_FRZ = 7'b0000000;
  localparam logic [6:0] EN_LU  = 7'b0011101;
  localparam logic [6:0] EN_BR  = 7'b1111111;
  localparam logic [6:0] EN_FL  = 7'b1111110;

  assign en = {pc_we, we_if_id, we_id_ex, we_ex_mem, we_mem_wb, flush_if_id, flush_id_ex};

  pipeline_hazard_ctrl u_dut (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rd (ex_rd), .ex_is_load (ex_is_load), .ex_we (ex_we),
    .ex_branch_taken (ex_branch_taken), .mem_req (mem_req), .mem_ack (mem_ack),
    .cnt_clr (cnt_clr),
    .pc_we (pc_we), .we_if_id (we_if_id), .we_id_ex (we_id_ex), .we_ex_mem (we_ex_mem),
    .we_mem_wb (we_mem_wb), .flush_if_id (flush_if_id), .flush_id_ex (flush_id_ex),
    .state (state), .stall_cnt (stall_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk (clk), .rst (rst),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .ex_rd (ex_rd), .ex_is_load (ex_is_load), .ex_we (ex_we),
    .ex_branch_taken (ex_branch_taken), .mem_req (mem_req), .mem_ack (mem_ack),
    .cnt_clr (cnt_clr),
    .pc_we (s_pc_we), .we_if_id (s_we_if_id), .we_id_ex (s_we_id_ex), .we_ex_mem (s_we_ex_mem),
    .we_mem_wb (s_we_mem_wb), .flush_if_id (s_flush_if_id), .flush_id_ex (s_flush_id_ex),
    .state (s_state), .stall_cnt (s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_we = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #3;
    total++;
    if (en !== EN_FRZ) begin bad++; $display("FAIL reset_en got=%b want=%b", en, EN_FRZ); end
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL idle_en got=%b want=%b", en, EN_RUN); end
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", state); end
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL idle_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    clear_cnt();
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5; id_use_rs2 = 1'b1;
    #1;
    total++;
    if (en !== EN_LU) begin bad++; $display("FAIL lu_en got=%b want=%b", en, EN_LU); end
    tick();
    idle_inputs();
    total++;
    if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd0; id_rs2 = 4'd0; id_use_rs2 = 1'b1;
    #1;
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL lu_r0_en got=%b want=%b", en, EN_RUN); end
    ex_rd = 4'd7; id_rs1 = 4'd7; id_use_rs1 = 1'b0; id_rs2 = 4'd3;
    #1;
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL lu_unused_en got=%b want=%b", en, EN_RUN); end
    id_use_rs1 = 1'b1;
    #1;
    total++;
    if (en !== EN_LU) begin bad++; $display("FAIL lu_rs1_en got=%b want=%b", en, EN_LU); end
    tick();
    idle_inputs();
    total++;
    if (stall_cnt !== 16'd2) begin bad++; $display("FAIL lu_cnt2 got=%0d want=2", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    clear_cnt();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (en !== EN_FRZ) begin bad++; $display("FAIL mw_en[%0d] got=%b want=%b", i, en, EN_FRZ); end
      tick();
      total++;
      if (state !== 2'd1) begin bad++; $display("FAIL mw_state[%0d] got=%0d want=1", i, state); end
    end
    mem_ack = 1'b1;
    #1;
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL mw_ack_en got=%b want=%b", en, EN_RUN); end
    tick();
    idle_inputs();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL mw_exit_state got=%0d want=0", state); end
    total++;
    if (stall_cnt !== 16'd3) begin bad++; $display("FAIL mw_cnt got=%0d want=3", stall_cnt); end
  endtask

  task automatic test_branch();
    clear_cnt();
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if (en !== EN_BR) begin bad++; $display("FAIL br_c0_en got=%b want=%b", en, EN_BR); end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    total++;
    if (en !== EN_FL) begin bad++; $display("FAIL br_c1_en got=%b want=%b", en, EN_FL); end
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL br_c1_state got=%0d want=2", state); end
    tick();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL br_c2_state got=%0d want=0", state); end
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL br_c2_en got=%b want=%b", en, EN_RUN); end
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL br_cnt got=%0d want=0", stall_cnt); end
  endtask

  task automatic test_branch_vs_load();
    clear_cnt();
    ex_branch_taken = 1'b1;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 4'd9; id_rs1 = 4'd9; id_use_rs1 = 1'b1;
    #1;
    total++;
    if (en !== EN_BR) begin bad++; $display("FAIL brlu_en got=%b want=%b", en, EN_BR); end
    tick();
    idle_inputs();
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL brlu_state got=%0d want=2", state); end
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL brlu_cnt got=%0d want=0", stall_cnt); end
    tick();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL brlu_exit_state got=%0d want=0", state); end
  endtask

  task automatic test_flush_mem();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    mem_req = 1'b1;
    #1;
    total++;
    if (en !== EN_FRZ) begin bad++; $display("FAIL flmw_en got=%b want=%b", en, EN_FRZ); end
    tick();
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL flmw_state got=%0d want=2", state); end
    mem_ack = 1'b1;
    #1;
    total++;
    if (en !== EN_FL) begin bad++; $display("FAIL flmw_ack_en got=%b want=%b", en, EN_FL); end
    tick();
    idle_inputs();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL flmw_exit_state got=%0d want=0", state); end
  endtask

  task automatic test_ack_branch();
    mem_req = 1'b1;
    tick();
    mem_ack = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if (en !== EN_BR) begin bad++; $display("FAIL ackbr_en got=%b want=%b", en, EN_BR); end
    tick();
    idle_inputs();
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL ackbr_state got=%0d want=2", state); end
    tick();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL ackbr_exit_state got=%0d want=0", state); end
  endtask

  task automatic test_rst_mid_wait();
    mem_req = 1'b1;
    tick();
    total++;
    if (state !== 2'd1) begin bad++; $display("FAIL rstmw_pre_state got=%0d want=1", state); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (en !== EN_FRZ) begin bad++; $display("FAIL rstmw_en got=%b want=%b", en, EN_FRZ); end
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL rstmw_state got=%0d want=0", state); end
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rstmw_cnt got=%0d want=0", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    tick();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL rstmw_post_state got=%0d want=0", state); end
    total++;
    if (en !== EN_RUN) begin bad++; $display("FAIL rstmw_post_en got=%b want=%b", en, EN_RUN); end
  endtask

  task automatic test_saturation();
    clear_cnt();
    mem_req = 1'b1;
    repeat (20) tick();
    total++;
    if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_wide_cnt got=%0d want=20", stall_cnt); end
    total++;
    if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d want=15", s_stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL clr_prio_cnt got=%0d want=0", stall_cnt); end
    total++;
    if (s_stall_cnt !== 4'd0) begin bad++; $display("FAIL clr_prio_sat got=%0d want=0", s_stall_cnt); end
    mem_ack = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL sat_exit_state got=%0d want=0", state); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_branch_vs_load();
    test_flush_mem();
    test_ack_branch();
    test_rst_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 4-stage-register pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB) of the image-filter processor. It drives every pipeline-register write enable, the PC write enable and the bubble-insert flushes. It resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses using a req/ack handshake in MEM. It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
RA_W, 4, register-address width (scalar and vector register files).
FLUSH_CYCLES, 2, number of consecutive cycles flush_if_id is held after a taken branch (>=1).
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
id_rs1  in  RA_W  source register 1 of the instruction in ID.
id_rs2  in  RA_W  source register 2 of the instruction in ID.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  RA_W  destination register of the instruction in EX.
ex_is_load  in  1  EX instruction is a load (data available only after MEM).
ex_we  in  1  EX instruction writes a register.
ex_branch_taken  in  1  branch resolved taken in EX.
mem_req  in  1  MEM stage holds an active memory access.
mem_ack  in  1  memory access completes this cycle.
cnt_clr  in  1  synchronous clear of stall_cnt.
pc_we  out  1  PC register write enable.
we_if_id, we_id_ex, we_ex_mem, we_mem_wb  out  1 each  pipeline-register write enables.
flush_if_id, flush_id_ex  out  1 each  load a bubble (all controls 0) instead of data.
state  out  2  current FSM state (debug).
stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0.

Behaviour:
- Reset (async, rst=1): state=RUN, flush counter=0, stall_cnt=0. While rst=1, all we_* and pc_we are 0 and both flushes are 0. The first rising edge after release is normal RUN operation.
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2. Only state and counters are registered. Outputs are combinational from state and current inputs, so stall and flush take effect with 0-cycle latency.
- Priority within a cycle: memory wait > branch flush > load-use stall.
- Memory wait:
  - Condition: mem_req=1 and mem_ack=0.
  - All we_*=0, pc_we=0, flushes=0.
  - Next state is MEM_WAIT.
- MEM_WAIT:
  - Outputs are held frozen as above until mem_ack=1.
  - In the ack cycle, all enables are 1 and the pipeline advances.
  - The next state is RUN, or FLUSH if ex_branch_taken=1 in that cycle.
  - A branch or hazard present during the wait is evaluated in the ack cycle, not earlier.
- Branch taken:
  - Condition: ex_branch_taken=1, no memory wait.
  - flush_if_id=1, flush_id_ex=1, all we_*=1, pc_we=1 (redirect).
  - If FLUSH_CYCLES>1, the next state is FLUSH with counter=FLUSH_CYCLES-1.
  - The branch overrides a simultaneous load-use stall; the dependent instruction is squashed anyway.
- FLUSH:
  - flush_if_id=1, all enables 1, counter decrements each cycle.
  - Return to RUN when counter reaches 1 and decrements.
  - A memory wait in FLUSH freezes the counter and outputs with the MEM_WAIT output pattern, but the state stays FLUSH.
  - A new taken branch in FLUSH reloads the counter and applies a full branch flush.
- Load-use stall:
  - Condition: ex_is_load & ex_we & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_we=0, we_if_id=0, flush_id_ex=1, we_id_ex/we_ex_mem/we_mem_wb=1.
  - Lasts exactly 1 cycle; the load advances to MEM and the hazard clears.
  - Register 0 never causes a stall.
- stall_cnt:
  - Increments on every cycle with pc_we=0, saturating at all-ones.
  - cnt_clr has priority over increment.

Decomposition:
- Shared package holds the FSM state encodings (RUN/MEM_WAIT/FLUSH) and RA_W.
- Sub-module: hazard_cmp, the purely combinational load-use comparator.

Test Plan:
1. Reset then idle, no requests → all we_*=1, pc_we=1, flushes=0, state=0, stall_cnt=0.
2. ex_is_load=1, ex_we=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle → pc_we=0, we_if_id=0, flush_id_ex=1 that cycle; stall_cnt=1. With ex_rd=0 → no stall.
3. mem_req=1, mem_ack=0 for 3 cycles, then ack → 3 cycles all enables 0, state=1; ack cycle all enables 1; stall_cnt=3; then state=0.
4. ex_branch_taken pulse with FLUSH_CYCLES=2 → both flushes=1 in cycle 0; flush_if_id=1 only in cycle 1, state=2; cycle 2 state=0.
5. Branch and load-use hazard in the same cycle → branch flush pattern with pc_we=1; no stall counted.
6. Assert rst mid MEM_WAIT → outputs 0 immediately; after release state=0 and stall_cnt=0; saturation check with CNT_W=4 reaches 15 and holds.
